// File: rtl/i2s_tx_stream.sv
`timescale 1ns/1ps
// Stereo I2S / left-justified transmitter: a fractional divider makes BCK, a one-entry buffer feeds a frame shifter.
// A pair accepted before a frame load leaves on DIN from that load's falling BCK; s_ready stays low while the buffer is full.
module i2s_tx_stream #(
    parameter int CLK_HZ = 12000000,
    parameter int BCK_HZ = 1411200,
    parameter int DATA_W = 16,
    parameter int SLOT_W = 16,
    parameter int FORMAT = 0,
    parameter int ACC_W  = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              bck,
    output logic              lrck,
    output logic              din,
    output logic              underrun
);
    localparam int FRAME_W = 2 * SLOT_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int PAD_W   = SLOT_W - DATA_W;
    localparam logic [ACC_W-1:0] INC      = ACC_W'(2 * BCK_HZ);
    localparam logic [ACC_W-1:0] LIM      = ACC_W'(CLK_HZ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic             LRCK_RST = (FORMAT != 0);

    logic [ACC_W-1:0]   acc_q, acc_d, sum;
    logic               bck_q, bck_d, lrck_q, lrck_d, din_q, din_d;
    logic               und_q, und_d, rdy_q, rdy_d, full_q, full_d;
    logic [DATA_W-1:0]  buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] sh_q, sh_d, frame;
    logic [SLOT_W-1:0]  l_slot, r_slot;
    logic               tick, fall, wrap, load;

    always_comb begin
        sum     = acc_q + INC;
        tick    = (sum >= LIM);
        acc_d   = tick ? (sum - LIM) : sum;
        bck_d   = bck_q ^ tick;
        fall    = tick & bck_q;
        wrap    = (cnt_q == CNT_LAST);
        load    = fall & wrap;
        // Samples are MSB-aligned in their slot; the low bits are padding.
        l_slot  = SLOT_W'(buf_l_q) << PAD_W;
        r_slot  = SLOT_W'(buf_r_q) << PAD_W;
        frame   = full_q ? {l_slot, r_slot} : '0;
        cnt_d   = cnt_q;
        lrck_d  = lrck_q;
        din_d   = din_q;
        sh_d    = sh_q;
        full_d  = full_q;
        buf_l_d = buf_l_q;
        buf_r_d = buf_r_q;
        und_d   = 1'b0;

        if (fall) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (load) begin
                din_d  = frame[FRAME_W-1];
                sh_d   = frame << 1;
                full_d = 1'b0;
                und_d  = !full_q;
            end else begin
                din_d = sh_q[FRAME_W-1];
                sh_d  = sh_q << 1;
            end
            if (FORMAT != 0) begin
                lrck_d = (cnt_d >= CNT_W'(SLOT_W));
            end else begin
                lrck_d = (cnt_d >= CNT_W'(SLOT_W - 1)) && (cnt_d <= CNT_W'(FRAME_W - 2));
            end
        end

        // A load and an accept in the same clk only coexist when the buffer was empty.
        if (s_valid && rdy_q) begin
            full_d  = 1'b1;
            buf_l_d = s_left;
            buf_r_d = s_right;
        end
        rdy_d = !full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            bck_q   <= 1'b0;
            lrck_q  <= LRCK_RST;
            din_q   <= 1'b0;
            und_q   <= 1'b0;
            rdy_q   <= 1'b1;
            full_q  <= 1'b0;
            buf_l_q <= '0;
            buf_r_q <= '0;
            cnt_q   <= CNT_LAST;
            sh_q    <= '0;
        end else begin
            acc_q   <= acc_d;
            bck_q   <= bck_d;
            lrck_q  <= lrck_d;
            din_q   <= din_d;
            und_q   <= und_d;
            rdy_q   <= rdy_d;
            full_q  <= full_d;
            buf_l_q <= buf_l_d;
            buf_r_q <= buf_r_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    assign bck      = bck_q;
    assign lrck     = lrck_q;
    assign din      = din_q;
    assign underrun = und_q;
    assign s_ready  = rdy_q;
endmodule

// File: tb/tb_i2s_tx_stream.sv
`timescale 1ns/1ps
// Three transmitter configurations run side by side; each has its own stimulus and a
// reference built from tick arithmetic and a queue of expected frames.
module tb_i2s_tx_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit done [3];

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int C     = (g == 0) ? 12000000 : (g == 1) ? 8 : 6000000;
        localparam int B     = (g == 1) ? 1 : 1411200;
        localparam int DW    = (g == 1) ? 12 : 16;
        localparam int SW    = 16;
        localparam int FMT   = (g == 0) ? 0 : 1;
        localparam int FR    = 2 * SW;
        localparam int FRCLK = int'((longint'(FR) * C) / B);

        logic          rst, s_valid, s_ready, bck, lrck, din, underrun;
        logic [DW-1:0] s_left, s_right;

        i2s_tx_stream #(
            .CLK_HZ(C), .BCK_HZ(B), .DATA_W(DW), .SLOT_W(SW), .FORMAT(FMT), .ACC_W(25)
        ) dut (
            .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
            .s_left(s_left), .s_right(s_right), .bck(bck), .lrck(lrck),
            .din(din), .underrun(underrun)
        );

        // Reference state: n clocks since reset give floor(n*2*B/C) BCK half-periods.
        longint          n;
        bit              m_full, m_bck, m_und;
        logic [DW-1:0]   m_l, m_r;
        logic [2*DW-1:0] fq [$];
        logic [2*DW-1:0] cur;
        int              rise;
        bit              bck_prev;
        bit              p_rst = 1'b1;
        bit              p_valid;
        logic [DW-1:0]   p_l, p_r;

        always @(negedge clk) begin
            longint        t_now, t_prev;
            int            p, ch, q;
            logic [DW-1:0] smp;
            bit            acc, exp_din, exp_lr;
            if (p_rst) begin
                n = 0; m_full = 0; m_bck = 0; m_und = 0;
                fq.delete(); cur = '0; rise = 0; bck_prev = 0;
            end else begin
                acc    = p_valid && !m_full;
                n      = n + 1;
                t_now  = (n * 2 * longint'(B)) / longint'(C);
                t_prev = ((n - 1) * 2 * longint'(B)) / longint'(C);
                m_und  = 0;
                if (t_now != t_prev) begin
                    m_bck = t_now[0];
                    // Every FR-th falling BCK, starting with the first, begins a frame.
                    if (!t_now[0] && ((t_now / 2 - 1) % FR == 0)) begin
                        if (m_full) fq.push_back({m_l, m_r});
                        else begin
                            fq.push_back('0);
                            m_und = 1;
                        end
                        m_full = 0;
                    end
                end
                if (acc) begin
                    m_full = 1; m_l = p_l; m_r = p_r;
                end
            end

            check("bck", g, 32'(bck), 32'(m_bck));
            check("s_ready", g, 32'(s_ready), 32'(!m_full));
            check("underrun", g, 32'(underrun), 32'(m_und));

            if (p_rst) begin
                check("rst_din", g, 32'(din), 32'(0));
                check("rst_lrck", g, 32'(lrck), 32'(FMT));
            end else if (bck && !bck_prev) begin
                rise++;
                p = (rise + FR - 2) % FR;
                if (rise >= 2 && p == 0) begin
                    check("frame_queue", g, 32'(fq.size()), 32'(1));
                    if (fq.size() != 0) cur = fq.pop_front();
                end
                ch  = p / SW;
                q   = p % SW;
                smp = (ch != 0) ? cur[DW-1:0] : cur[2*DW-1:DW];
                exp_din = 1'b0;
                if (q < DW) exp_din = smp[DW-1-q];
                exp_lr = (FMT != 0) ? (ch != 0) : ((((p + 1) % FR) / SW) != 0);
                check("din_bit", g, 32'(din), 32'(exp_din));
                check("lrck_bit", g, 32'(lrck), 32'(exp_lr));
            end

            bck_prev = bck;
            p_rst    = rst;
            p_valid  = s_valid;
            p_l      = s_left;
            p_r      = s_right;
        end

        task automatic step(input int k);
            repeat (k) @(posedge clk);
            #1;
        endtask

        task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
            bit rdy;
            int w;
            s_valid = 1'b1; s_left = l; s_right = r;
            rdy = 1'b0; w = 0;
            while (!rdy && w <= 3 * FRCLK) begin
                @(negedge clk);
                rdy = s_ready;
                step(1);
                w++;
            end
            s_valid = 1'b0;
            check("send_accept", g, 32'(rdy), 32'(1));
        endtask

        initial begin
            logic [DW-1:0] a, b;
            rst = 1'b1; s_valid = 1'b0; s_left = '0; s_right = '0;
            step(3);
            rst = 1'b0;
            // Three silent frames: zero data and an underrun pulse at each load.
            step(3 * FRCLK);
            a = DW'(32'hA5F0);
            b = DW'(32'h0F0F);
            if (g == 1) a = '1;
            send(a, b);
            step(2 * FRCLK);
            for (int k = 0; k < 10; k++) begin
                if ($urandom_range(0, 3) == 0) step($urandom_range(1, FRCLK));
                send(DW'(16'h0100 + k), DW'($urandom));
            end
            // This pair is still buffered when reset hits and must never appear.
            send(DW'(32'hBEEF), DW'(32'hCAFE));
            step($urandom_range(FRCLK / 8, FRCLK / 2));
            rst = 1'b1;
            step(1);
            rst = 1'b0;
            step(2);
            for (int k = 0; k < 3; k++) send(DW'($urandom), DW'($urandom));
            step(2 * FRCLK);
            done[g] = 1'b1;
        end
    end

    initial begin
        int w = 0;
        while (!(done[0] && done[1] && done[2]) && w < 50000) begin
            @(posedge clk);
            w++;
        end
        check("all_done", 0, 32'(done[0] && done[1] && done[2]), 32'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
